// File: rtl/piece_generator.sv
// Piece generator: Galois LFSR draws piece codes into a short preview queue popped by the game controller.
// Optional NO_REPEAT_EN build also rejects a draw equal to the most recently queued code.
module piece_generator #(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          NUM_TYPES   = 5,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nextPiece,
  input  logic        seedLoad,
  input  logic [15:0] seedValue,
  output logic [2:0]  blockType,
  output logic        blockValid,
  output logic [2:0]  previewType,
  output logic        previewValid
);

  localparam int            CW      = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [3:0]    NT      = 4'(NUM_TYPES);

  typedef enum logic {FILL, FULL} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [15:0]   r_lfsr;
  logic [CW-1:0] r_count;
  logic [2:0]    r_entry [QUEUE_DEPTH];
  logic [2:0]    w_cand;
  logic          w_accept;
  logic          w_pop;
  logic          w_repeat;
  logic [CW-1:0] w_wr_idx;

  assign w_cand   = r_lfsr[2:0];
  assign w_pop    = nextPiece && (r_count != '0);
  // A same-cycle pop frees the head slot, so the new code lands one slot earlier.
  assign w_wr_idx = w_pop ? (r_count - ONE) : r_count;

`ifdef NO_REPEAT_EN
  logic [2:0] r_last;

  assign w_repeat = (w_cand == r_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= 3'd0;
    end else if (w_accept) begin
      r_last <= w_cand;
    end
  end
`else
  assign w_repeat = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      FILL: begin
        w_accept = ({1'b0, w_cand} < NT) && !w_repeat;
        if (w_accept && !w_pop && (r_count == DEPTH_C - ONE)) begin
          w_state_next = FULL;
        end
      end
      FULL: begin
        if (w_pop) begin
          w_state_next = FILL;
        end
      end
      default: w_state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The LFSR keeps running while the queue is full; reload wins over the shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else if (seedLoad) begin
      r_lfsr <= (seedValue == 16'd0) ? SEED : seedValue;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_accept && !w_pop) begin
      r_count <= r_count + ONE;
    end else if (!w_accept && w_pop) begin
      r_count <= r_count - ONE;
    end
  end

  // Shift first, then the push; the later assignment wins where both hit a slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        r_entry[i] <= 3'd0;
      end
    end else begin
      if (w_pop) begin
        for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
          r_entry[i] <= r_entry[i+1];
        end
      end
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (w_accept && (w_wr_idx == CW'(i))) begin
          r_entry[i] <= w_cand;
        end
      end
    end
  end

  assign blockType    = r_entry[0];
  assign previewType  = r_entry[1];
  assign blockValid   = (r_count != '0);
  assign previewValid = (r_count >= CW'(2));

endmodule
